// File: rtl/score_tracker.sv
// score_tracker: judgement score/combo accumulator with a timed popup sprite.
//
// Parameters:
//   POPUP_FRAMES  vs rising edges a popup stays visible (1..255)
//   HIT_PTS       base points for a hit
//   GOOD_PTS      base points for a good
// Optional feature macro: SCORE_COMBO_BONUS_EN
//   When defined, a hit or good also adds (combo before the update >> 3).
//
// Ports:
//   Clk           system clock, all state on rising edge
//   Reset_n       asynchronous active-low reset
//   vs            vertical sync level, synchronous to Clk
//   song_start    one-cycle pulse, clears score state for a new song
//   judge_valid   one-cycle pulse, judgement event
//   judge_code    01 hit, 10 good, 11 miss, 00 ignored
//   score         accumulated score (saturates at 16'hFFFF)
//   combo         consecutive hit/good count (saturates at 255)
//   max_combo     highest combo this song
//   popup_active  popup sprite visible
//   popupID       popup sprite ID (8 hit, A good, 9 miss, 0 idle)
//   popupX/Y      fixed popup position
module score_tracker #(
  parameter int unsigned POPUP_FRAMES = 30,
  parameter int unsigned HIT_PTS      = 100,
  parameter int unsigned GOOD_PTS     = 50
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vs,
  input  logic        song_start,
  input  logic        judge_valid,
  input  logic [1:0]  judge_code,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic        popup_active,
  output logic [3:0]  popupID,
  output logic [9:0]  popupX,
  output logic [9:0]  popupY
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [7:0]  max_combo_q, max_combo_d;
  logic [3:0]  popup_id_q, popup_id_d;
  logic        popup_active_q, popup_active_d;
  logic        vs_q, vs_d;

  logic        accept;
  logic        vs_rise;
  logic        is_hit, is_good, is_miss;
  logic [16:0] add_pts;
  logic [16:0] sum;
  logic [7:0]  combo_new;

  always_comb begin
    vs_d    = vs;
    vs_rise = vs & ~vs_q;
    // song_start drops a coincident event
    accept  = judge_valid && (judge_code != 2'b00) && !song_start;
    is_hit  = (judge_code == 2'b01);
    is_good = (judge_code == 2'b10);
    is_miss = (judge_code == 2'b11);

    add_pts = '0;
    if (is_hit)  add_pts = 17'(HIT_PTS);
    if (is_good) add_pts = 17'(GOOD_PTS);
`ifdef SCORE_COMBO_BONUS_EN
    if (is_hit || is_good) add_pts = add_pts + 17'(combo_q >> 3);
`endif
    sum = {1'b0, score_q} + add_pts;

    combo_new = combo_q;
    if (is_miss)                combo_new = '0;
    else if (combo_q != 8'hFF)  combo_new = combo_q + 8'd1;

    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    popup_id_d  = popup_id_q;

    if (song_start) begin
      score_d     = '0;
      combo_d     = '0;
      max_combo_d = '0;
      state_d     = IDLE;
      cnt_d       = '0;
      popup_id_d  = 4'h0;
    end else if (accept) begin
      // Event wins over a coincident vs rise: reload, no decrement
      score_d     = sum[16] ? '1 : sum[15:0];
      combo_d     = combo_new;
      max_combo_d = (combo_new > max_combo_q) ? combo_new : max_combo_q;
      state_d     = SHOW;
      cnt_d       = 8'(POPUP_FRAMES);
      popup_id_d  = is_hit ? 4'h8 : (is_good ? 4'hA : 4'h9);
    end else if (state_q == SHOW && vs_rise) begin
      if (cnt_q == 8'd1) begin
        state_d    = IDLE;
        cnt_d      = '0;
        popup_id_d = 4'h0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    popup_active_d = (state_d == SHOW);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      score_q        <= '0;
      combo_q        <= '0;
      max_combo_q    <= '0;
      popup_id_q     <= 4'h0;
      popup_active_q <= 1'b0;
      vs_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_q        <= score_d;
      combo_q        <= combo_d;
      max_combo_q    <= max_combo_d;
      popup_id_q     <= popup_id_d;
      popup_active_q <= popup_active_d;
      vs_q           <= vs_d;
    end
  end

  assign score        = score_q;
  assign combo        = combo_q;
  assign max_combo    = max_combo_q;
  assign popup_active = popup_active_q;
  assign popupID      = popup_id_q;
  assign popupX       = 10'h140;
  assign popupY       = 10'h0F0;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with default parameters.
module tb_score_tracker;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vs;
  logic        song_start;
  logic        judge_valid;
  logic [1:0]  judge_code;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic        popup_active;
  logic [3:0]  popupID;
  logic [9:0]  popupX;
  logic [9:0]  popupY;

  int unsigned checks = 0;
  int unsigned errors = 0;

  score_tracker #(.POPUP_FRAMES(30), .HIT_PTS(100), .GOOD_PTS(50)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .song_start(song_start),
    .judge_valid(judge_valid), .judge_code(judge_code),
    .score(score), .combo(combo), .max_combo(max_combo),
    .popup_active(popup_active), .popupID(popupID),
    .popupX(popupX), .popupY(popupY)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic judge(input logic [1:0] code);
    judge_valid = 1'b1;
    judge_code  = code;
    tick();
    judge_valid = 1'b0;
    judge_code  = 2'b00;
  endtask

  task automatic restart();
    song_start = 1'b1;
    tick();
    song_start = 1'b0;
  endtask

  // One full vs pulse; the rise is sampled at the first edge
  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
  endtask

  initial begin
    logic ok;
    Reset_n     = 1'b0;
    vs          = 1'b0;
    song_start  = 1'b0;
    judge_valid = 1'b0;
    judge_code  = 2'b00;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_combo", 32'(combo), 32'd0);
    chk("rst_max", 32'(max_combo), 32'd0);
    chk("rst_active", 32'(popup_active), 32'd0);
    chk("rst_id", 32'(popupID), 32'h0);
    chk("rst_x", 32'(popupX), 32'h140);
    chk("rst_y", 32'(popupY), 32'h0F0);

    // Three hits
    for (int i = 0; i < 3; i++) judge(2'b01);
    chk("hit3_score", 32'(score), 32'd300);
    chk("hit3_combo", 32'(combo), 32'd3);
    chk("hit3_max", 32'(max_combo), 32'd3);
    chk("hit3_id", 32'(popupID), 32'h8);
    chk("hit3_active", 32'(popup_active), 32'd1);

    restart();
    chk("ss_score", 32'(score), 32'd0);
    chk("ss_max", 32'(max_combo), 32'd0);
    chk("ss_active", 32'(popup_active), 32'd0);

    // Five goods then a miss
    for (int i = 0; i < 5; i++) judge(2'b10);
    chk("good5_id", 32'(popupID), 32'hA);
    chk("good5_combo", 32'(combo), 32'd5);
    judge(2'b11);
    chk("miss_combo", 32'(combo), 32'd0);
    chk("miss_max", 32'(max_combo), 32'd5);
    chk("miss_score", 32'(score), 32'd250);
    chk("miss_id", 32'(popupID), 32'h9);

    // Code 00 is ignored
    judge(2'b00);
    chk("ign_score", 32'(score), 32'd250);
    chk("ign_id", 32'(popupID), 32'h9);

    // Popup lifetime: visible through 29 rises, gone after the 30th
    restart();
    judge(2'b01);
    ok = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      vs_pulse();
      if (popup_active !== 1'b1) ok = 1'b0;
    end
    chk("life_29", 32'(ok), 32'd1);
    vs = 1'b1;
    tick();
    chk("life_30", 32'(popup_active), 32'd0);
    chk("life_id", 32'(popupID), 32'h0);
    vs = 1'b0;
    tick();

    // Event and vs rise together at count 1: counter reloads to 30
    judge(2'b10);
    for (int i = 1; i <= 29; i++) vs_pulse();
    vs = 1'b1;
    judge_valid = 1'b1;
    judge_code  = 2'b01;
    tick();
    judge_valid = 1'b0;
    judge_code  = 2'b00;
    vs = 1'b0;
    tick();
    chk("coin_active", 32'(popup_active), 32'd1);
    chk("coin_id", 32'(popupID), 32'h8);
    for (int i = 1; i <= 29; i++) vs_pulse();
    chk("coin_29", 32'(popup_active), 32'd1);
    vs = 1'b1;
    tick();
    chk("coin_30", 32'(popup_active), 32'd0);
    vs = 1'b0;
    tick();

    // Asynchronous reset mid-popup
    judge(2'b01);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_active", 32'(popup_active), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_id", 32'(popupID), 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();
    vs_pulse();
    vs_pulse();
    chk("arst_stay", 32'(popup_active), 32'd0);

    // song_start with a simultaneous hit drops the hit
    judge(2'b01);
    song_start  = 1'b1;
    judge_valid = 1'b1;
    judge_code  = 2'b01;
    tick();
    song_start  = 1'b0;
    judge_valid = 1'b0;
    judge_code  = 2'b00;
    chk("ssh_score", 32'(score), 32'd0);
    chk("ssh_combo", 32'(combo), 32'd0);
    chk("ssh_active", 32'(popup_active), 32'd0);

`ifdef SCORE_COMBO_BONUS_EN
    // Ninth hit sees combo 8 -> bonus 1
    for (int i = 0; i < 9; i++) judge(2'b01);
    chk("bonus_score", 32'(score), 32'd901);
    restart();
`endif

    // Combo and score saturation
    judge_valid = 1'b1;
    judge_code  = 2'b01;
    repeat (655) tick();
    judge_valid = 1'b0;
    judge_code  = 2'b00;
`ifndef SCORE_COMBO_BONUS_EN
    chk("sat_pre", 32'(score), 32'hFFDC);
`endif
    chk("sat_combo", 32'(combo), 32'd255);
    chk("sat_max", 32'(max_combo), 32'd255);
    judge(2'b01);
    chk("sat_score", 32'(score), 32'hFFFF);
    chk("sat_combo2", 32'(combo), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter POPUP_FRAMES, default 30, number of vs rising edges a judgement popup stays visible (1..255).
REQ-002 SHALL have parameter HIT_PTS, default 100, base points for a hit.
REQ-003 SHALL have parameter GOOD_PTS, default 50, base points for a good.
REQ-004 SHALL have ports, clock and reset first:
  Clk  in  1  system clock; one clock, all state on rising edge
  Reset_n  in  1  reset, asynchronous, active-low
  vs  in  1  vertical sync level, synchronous to Clk
  song_start  in  1  one-cycle pulse, clears score state for a new song
  judge_valid  in  1  one-cycle pulse, judgement event from the upstream judgement stage
  judge_code  in  2  01 hit, 10 good, 11 miss, 00 ignored
  score  out  16  accumulated score
  combo  out  8  current consecutive hit/good count
  max_combo  out  8  highest combo this song
  popup_active  out  1  popup sprite visible
  popupID  out  4  popup sprite ID
  popupX  out  10  popup X position
  popupY  out  10  popup Y position

Function
REQ-005 SHALL accept an event when judge_valid=1 and judge_code!=00; events with code 00 SHALL change nothing.
REQ-006 SHALL update score, combo, max_combo and popup registers on the clock edge that samples the accepted event (outputs reflect it one cycle later).
REQ-007 Hit/good SHALL increment combo, saturating at 255; miss SHALL clear combo to 0.
REQ-008 max_combo SHALL equal the maximum of its old value and the new combo value, computed on the same edge.
REQ-009 Hit SHALL add HIT_PTS, good SHALL add GOOD_PTS, miss SHALL add 0; score SHALL saturate at 16'hFFFF, never wrap.
REQ-010 SHALL detect vs rising edge with one registered copy of vs (rise = vs & ~vs_q).
REQ-011 Popup FSM SHALL have states IDLE and SHOW.
REQ-012 IDLE: popup_active=0, popupID=4'h0; accepted event -> SHOW, frame counter loaded with POPUP_FRAMES.
REQ-013 SHOW: popup_active=1, popupX=10'h140, popupY=10'h0F0; popupID 4'h8 hit, 4'hA good, 4'h9 miss (from latest event).
REQ-014 SHOW: on vs rise, counter==1 -> IDLE, else counter decrements.
REQ-015 Accepted event in SHOW SHALL reload counter and replace popupID.
REQ-016 Event and vs rise in same cycle SHALL treat the event as winning: counter reloaded, no decrement.
REQ-017 song_start SHALL clear score, combo, max_combo to 0 and force IDLE next cycle; an event in the same cycle SHALL be dropped.
REQ-018 popupX/popupY SHALL hold 10'h140/10'h0F0 in IDLE too; only popup_active gates visibility.

Reset
REQ-019 Reset_n=0 SHALL immediately set score=0, combo=0, max_combo=0, FSM=IDLE, counter=0, vs_q=0, popupID=4'h0, popup_active=0.
REQ-020 Reset asserted mid-popup SHALL abort it; after release no popup until a new accepted event.

Configuration
REQ-021 Macro SCORE_COMBO_BONUS_EN defined: hit/good SHALL add base + (combo before the update >> 3), then saturate per REQ-009.
REQ-022 Macro undefined: only base points per REQ-009; no bonus logic compiled.

Verification
REQ-023 Reset, then 3 hits (judge_code=01) on separate cycles -> score=300, combo=3, max_combo=3, popupID=4'h8, popup_active=1 (bonus macro undefined).
REQ-024 5 goods then 1 miss -> combo=0, max_combo=5, score=250, popupID=4'h9.
REQ-025 One hit, then 30 vs rising edges -> popup_active stays 1 through 29th edge, 0 one cycle after 30th; hit and vs rise same cycle at count 1 -> stays SHOW, counter=30.
REQ-026 score preloaded to 16'hFFC0 via 1 hit from 16'hFF5C then another hit -> score=16'hFFFF, not wrapped; 260 hits -> combo=255.
REQ-027 SCORE_COMBO_BONUS_EN defined: 9 hits -> 9th adds 101, score=901; song_start with simultaneous hit -> score=0, combo=0, popup_active=0.
